instruction_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch widths, memory geometry, state and entry types
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;
  localparam int FETCH_MEM_DEPTH  = 40;
  localparam int FETCH_RESET_PC   = 0;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  // Head entry comes straight from storage, so the output is a register, not a path from the write side.
  assign rd_entry = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the buffer and dominates push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, fetch FSM and decode-side fetch queue
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int MEM_DEPTH  = FETCH_MEM_DEPTH,
  parameter int RESET_PC   = FETCH_RESET_PC,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  localparam int                    CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] END_PC = ADDR_WIDTH'(MEM_DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic            pc_in_range;
  logic            push;
  logic            pop;
  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

  assign pc_in_range = (pc < END_PC);
  assign pop         = id_ready & ~buf_empty;
  assign wr_entry    = '{pc: pc, instr: imem_data};

  assign imem_addr = pc;
  assign if_valid  = (buf_count != '0);
  assign if_pc     = rd_entry.pc;
  assign if_instr  = rd_entry.instr;
  assign halted    = (state == HALT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next state: redirect always re-enters FETCH; running off the end of memory halts.
  always_comb begin
    state_next = state;
    if (redirect_valid)                    state_next = FETCH;
    else if (state == FETCH && !pc_in_range) state_next = HALT;
  end

  // Push/pop decode: a redirect cycle neither fetches nor consumes, it only flushes.
  always_comb begin
    push    = 1'b0;
    buf_pop = 1'b0;
    if (!redirect_valid) begin
      buf_pop = pop;
      push    = (state == FETCH) && pc_in_range && (!buf_full || pop);
    end
  end

  // Program counter: redirect target wins, otherwise advance by one word per accepted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               pc <= ADDR_WIDTH'(RESET_PC);
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + ADDR_WIDTH'(1);
  end

  // Count of words written into the buffer since reset, free-running modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     fetch_count <= '0;
    else if (push) fetch_count <= fetch_count + 32'd1;
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .pop      (buf_pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int MEM_WORDS = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_halted;

  always #5 clk = ~clk;

  // Instruction memory image: mem[i] = 0x1000_0000 + i.
  always_comb imem_data = (imem_addr < 32'd40) ? 32'h1000_0000 + imem_addr : 32'hDEAD_BEEF;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc     = 32'd0;
    m_count  = 32'd0;
    m_halted = 1'b0;
  endfunction

  // One clock edge of the fetch unit as seen from outside: a queue of fetched words.
  function automatic void model_step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic popv;
    logic was_out;
    logic can;
    popv    = (mq.size() != 0) && rdy;
    was_out = (m_pc >= MEM_WORDS);
    if (redir) begin
      mq.delete();
      m_pc     = rpc;
      m_halted = 1'b0;
    end else begin
      can = !m_halted && !was_out && ((mq.size() < 2) || popv);
      if (popv) void'(mq.pop_front());
      if (can) begin
        mq.push_back({m_pc, 32'h1000_0000 + m_pc});
        m_pc    = m_pc + 32'd1;
        m_count = m_count + 32'd1;
      end
      m_halted = m_halted || was_out;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ":valid"}, 64'(if_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({tag, ":pc"},    64'(if_pc),    64'(mq[0][63:32]));
      check({tag, ":instr"}, 64'(if_instr), 64'(mq[0][31:0]));
    end
    check({tag, ":halted"}, 64'(halted),      64'(m_halted));
    check({tag, ":count"},  64'(fetch_count), 64'(m_count));
    check({tag, ":addr"},   64'(imem_addr),   64'(m_pc));
  endtask

  task automatic step(input string tag, input logic rdy, input logic redir, input logic [31:0] rpc);
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    model_step(rdy, redir, rpc);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int guard;
    logic [31:0] last_pc;

    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    check("reset_if_instr", 64'(if_instr), 64'd0);
    check("reset_if_pc",    64'(if_pc),    64'd0);
    reset = 1'b0;

    // Stream with decode always ready until pc 3 is at the head.
    guard = 0;
    do begin
      step("stream", 1'b1, 1'b0, 32'd0);
      guard++;
    end while (!(mq.size() != 0 && mq[0][63:32] == 32'd3) && guard < 20);
    check("reach_pc3", 64'(if_pc), 64'd3);

    // Decode stalls for five cycles: buffer holds 3,4 and fetch address parks at 5.
    repeat (5) step("stall", 1'b0, 1'b0, 32'd0);
    check("stall_addr",  64'(imem_addr), 64'd5);
    check("stall_instr", 64'(if_instr),  64'h1000_0003);
    step("drain", 1'b1, 1'b0, 32'd0);
    check("drain_pc4", 64'(if_pc), 64'd4);
    step("drain", 1'b1, 1'b0, 32'd0);
    check("drain_pc5", 64'(if_pc), 64'd5);

    // Redirect to 20 with a full buffer and decode ready.
    repeat (2) step("fill", 1'b0, 1'b0, 32'd0);
    step("redir20", 1'b1, 1'b1, 32'd20);
    check("redir_bubble", 64'(if_valid), 64'd0);
    step("redir20b", 1'b1, 1'b0, 32'd0);
    check("redir_valid", 64'(if_valid), 64'd1);
    check("redir_pc",    64'(if_pc),    64'd20);
    check("redir_instr", 64'(if_instr), 64'h1000_0014);

    // Random backpressure and redirects, including targets past the end of memory.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           32'($urandom_range(0, 47)));
    end

    // Asynchronous reset with two entries buffered.
    step("pre_rst", 1'b1, 1'b1, 32'd0);
    repeat (3) step("pre_rst", 1'b0, 1'b0, 32'd0);
    check("pre_rst_valid", 64'(if_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid",  64'(if_valid),    64'd0);
    check("async_halted", 64'(halted),      64'd0);
    check("async_count",  64'(fetch_count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all("post_rst");

    // Free run to the end of memory.
    guard   = 0;
    last_pc = 32'hFFFF_FFFF;
    while (!(m_halted && mq.size() == 0) && guard < 100) begin
      if (if_valid) last_pc = if_pc;
      step("run", 1'b1, 1'b0, 32'd0);
      guard++;
    end
    if (guard >= 100) check("run_timeout", 64'd1, 64'd0);
    check("end_last_pc", 64'(last_pc),     64'd39);
    check("end_halted",  64'(halted),      64'd1);
    check("end_valid",   64'(if_valid),    64'd0);
    check("end_count",   64'(fetch_count), 64'd40);

    // Leave HALT with an in-range redirect.
    step("redir7", 1'b1, 1'b1, 32'd7);
    check("redir7_halted", 64'(halted), 64'd0);
    step("redir7b", 1'b1, 1'b0, 32'd0);
    check("redir7_pc", 64'(if_pc), 64'd7);

    // Redirect past the end: FETCH for one cycle, then HALT, nothing delivered.
    step("redir45", 1'b1, 1'b1, 32'd45);
    check("redir45_halted0", 64'(halted), 64'd0);
    step("redir45b", 1'b1, 1'b0, 32'd0);
    check("redir45_halted1", 64'(halted),   64'd1);
    check("redir45_valid",   64'(if_valid), 64'd0);
    repeat (3) step("redir45c", 1'b1, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
